dma_ctrl: RTL and testbench



---
 rtl/dma_ctrl_pkg.sv | 22 ++
 rtl/dma_addr_cnt.sv | 41 ++++
 rtl/dma_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_dma_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ctrl_pkg.sv
// Shared types and default widths for the dma_ctrl transfer engine.
package dma_ctrl_pkg;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_DATA_W = 16;
    localparam int DMA_CNT_W  = 8;
    localparam int DMA_BURST  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_REL   = 3'd4
    } dma_state_e;

    // The bus request is held across the whole tenure, including retries after a lost grant.
    function automatic logic holds_bus(input dma_state_e s);
        return (s == ST_REQ) || (s == ST_READ) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/dma_addr_cnt.sv
// Loadable address incrementer; the next value is exported so the owner can register it onto the bus.
module dma_addr_cnt
    import dma_ctrl_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] addr_nxt_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Next address: load wins over increment; increment wraps modulo 2^ADDR_W.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_W'(1'b1);
        end else begin
            addr_d = addr_q;
        end
    end

    // Address register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= {ADDR_W{1'b0}};
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_nxt_o = addr_d;

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel DMA engine owning the DMA side of the bus arbitration handshake.
// Optional periodic bus release every BURST words is compiled in with DMA_BURST_LIMIT_EN.
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int CNT_W  = DMA_CNT_W,
    parameter int BURST  = DMA_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  xfer_cnt,
    output logic              busy,
    output logic              done_irq,
    output logic              dma_breq,
    input  logic              dma_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              scan_in0,
    input  logic              scan_en,
    output logic              scan_out0
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    if (BURST < 1) begin : g_burst_check
        $error("dma_ctrl: BURST must be at least 1");
    end

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load_s, inc_s, done_d;
    logic [ADDR_W-1:0] src_nxt_s, dst_nxt_s;

    logic              busy_q, busy_d, done_q, breq_q, breq_d;
    logic              rd_q, rd_d, wr_q, wr_d, scan_q, scan_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef DMA_BURST_LIMIT_EN
    localparam int BCW = $clog2(BURST + 1);
    localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST);
    logic [BCW-1:0] burst_q, burst_d;
`endif

    dma_addr_cnt #(.ADDR_W(ADDR_W)) u_src_cnt (
        .clk_i      (clk),
        .rst_n_i    (reset),
        .load_i     (load_s),
        .inc_i      (inc_s),
        .load_val_i (src_addr),
        .addr_nxt_o (src_nxt_s)
    );

    dma_addr_cnt #(.ADDR_W(ADDR_W)) u_dst_cnt (
        .clk_i      (clk),
        .rst_n_i    (reset),
        .load_i     (load_s),
        .inc_i      (inc_s),
        .load_val_i (dst_addr),
        .addr_nxt_o (dst_nxt_s)
    );

    // Transfer sequencing: state, remaining count, data and burst bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        load_s  = 1'b0;
        inc_s   = 1'b0;
        done_d  = 1'b0;
`ifdef DMA_BURST_LIMIT_EN
        burst_d = burst_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && (xfer_cnt != CNT_ZERO)) begin
                    load_s  = 1'b1;
                    cnt_d   = xfer_cnt;
                    state_d = ST_REQ;
`ifdef DMA_BURST_LIMIT_EN
                    burst_d = {BCW{1'b0}};
`endif
                end else if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dma_grant) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_READ: begin
                if (bus_ack) begin
                    data_d  = bus_rdata;
                    state_d = ST_WRITE;
                end else if (!dma_grant) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (bus_ack) begin
                    inc_s = 1'b1;
                    cnt_d = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : CNT_ZERO;
`ifdef DMA_BURST_LIMIT_EN
                    burst_d = burst_q + BCW'(1'b1);
`endif
                    if (cnt_d == CNT_ZERO) begin
                        state_d = ST_REL;
                        done_d  = 1'b1;
                    end
`ifdef DMA_BURST_LIMIT_EN
                    else if (burst_d == BURST_MAX) begin
                        state_d = ST_REL;
                    end
`endif
                    else begin
                        state_d = ST_READ;
                    end
                end else if (!dma_grant) begin
                    // Counters untouched: the whole word is retried after regrant.
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_REL: begin
`ifdef DMA_BURST_LIMIT_EN
                burst_d = {BCW{1'b0}};
`endif
                state_d = (cnt_q == CNT_ZERO) ? ST_IDLE : ST_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every bus output comes straight from a flop.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        breq_d  = holds_bus(state_d);
        rd_d    = (state_d == ST_READ);
        wr_d    = (state_d == ST_WRITE);
        addr_d  = {ADDR_W{1'b0}};
        wdata_d = {DATA_W{1'b0}};
        if (state_d == ST_READ) begin
            addr_d = src_nxt_s;
        end else if (state_d == ST_WRITE) begin
            addr_d  = dst_nxt_s;
            wdata_d = data_d;
        end else begin
            addr_d = {ADDR_W{1'b0}};
        end
        scan_d = scan_en ? scan_in0 : 1'b0;
    end

    // Control state, count, data and burst registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            data_q  <= {DATA_W{1'b0}};
`ifdef DMA_BURST_LIMIT_EN
            burst_q <= {BCW{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef DMA_BURST_LIMIT_EN
            burst_q <= burst_d;
`endif
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            breq_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            scan_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            breq_q  <= breq_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            scan_q  <= scan_d;
        end
    end

    assign busy      = busy_q;
    assign done_irq  = done_q;
    assign dma_breq  = breq_q;
    assign bus_rd    = rd_q;
    assign bus_wr    = wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign scan_out0 = scan_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: stimulus queues expected bus accesses, tenures and completions; a monitor checks them.
module tb_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  xfer_cnt;
    logic        busy, done_irq, dma_breq, dma_grant;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_rd, bus_wr, bus_ack;
    logic        scan_in0, scan_en, scan_out0;

    logic ack_en, grant_allow, breq_seen;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    acc_t exp_q[$];
    int   ten_q[$];
    bit   done_q[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    assign bus_ack   = ack_en;
    assign bus_rdata = mem_val(bus_addr);

    dma_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .xfer_cnt(xfer_cnt),
        .busy(busy), .done_irq(done_irq), .dma_breq(dma_breq), .dma_grant(dma_grant),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .scan_in0(scan_in0), .scan_en(scan_en), .scan_out0(scan_out0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_xfer(input logic [15:0] s, input logic [15:0] d, input int n);
        logic [15:0] sa, da;
        sa = s;
        da = d;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{wr: 1'b0, addr: sa, data: 16'h0000});
            exp_q.push_back('{wr: 1'b1, addr: da, data: mem_val(sa)});
            sa = sa + 16'h0001;
            da = da + 16'h0001;
        end
        done_q.push_back(1'b1);
    endtask

    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                            input string tag);
        bit got;
        step();
        start = 1'b1; src_addr = s; dst_addr = d; xfer_cnt = n;
        step();
        start = 1'b0;
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_breq_c1"}, dma_breq, 1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (done_irq) got = 1'b1;
            else step();
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_breq_at_done"}, dma_breq, 0);
        chk({tag, "_busy_at_done"}, busy, 1);
        step();
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_pulse"}, done_irq, 0);
    endtask

    // Arbiter model: grants one cycle after the request is first seen.
    initial begin
        dma_grant = 1'b0;
        breq_seen = 1'b0;
        forever begin
            @(negedge clk);
            dma_grant = grant_allow & dma_breq & breq_seen;
            breq_seen = dma_breq;
        end
    end

    // Monitor: pops expectations whenever the DUT completes an access, a tenure or a transfer.
    initial begin
        acc_t e;
        int   wcnt = 0;
        int   cyc = 0;
        int   fall_cyc = 0;
        bit   prev_breq = 1'b0;
        bit   prev_wr_ack = 1'b0;
        bit   gap_pending = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (!reset) begin
                wcnt = 0; prev_breq = 1'b0; prev_wr_ack = 1'b0; gap_pending = 1'b0;
            end else begin
                if ((bus_rd || bus_wr) && bus_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_access", {15'd0, bus_wr, bus_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc_kind", bus_wr, e.wr);
                        chk("acc_addr", bus_addr, e.addr);
                        if (e.wr) chk("acc_wdata", bus_wdata, e.data);
                    end
                    if (bus_wr) wcnt++;
                end
                if (done_irq) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        void'(done_q.pop_front());
                        chk("done_pending_acc", exp_q.size(), 0);
                        if (busy) chk("done_after_last_ack", prev_wr_ack, 1);
                    end
                end
                if (prev_breq && !dma_breq) begin
                    if (ten_q.size() == 0) chk("unexpected_tenure", wcnt, 32'hFFFF);
                    else chk("tenure_words", wcnt, ten_q.pop_front());
                    wcnt = 0;
                    gap_pending = !done_irq;
                    fall_cyc = cyc;
                end
                if (!prev_breq && dma_breq && gap_pending) begin
                    chk("release_gap", cyc - fall_cyc, 1);
                    gap_pending = 1'b0;
                end
                prev_breq   = dma_breq;
                prev_wr_ack = bus_wr && bus_ack;
            end
        end
    end

    initial begin
        bit got;
        reset = 1'b0; start = 1'b0; src_addr = 16'h0000; dst_addr = 16'h0000; xfer_cnt = 8'd0;
        ack_en = 1'b1; grant_allow = 1'b1; scan_in0 = 1'b1; scan_en = 1'b0;
        repeat (3) step();
        chk("reset_outputs", {busy, done_irq, dma_breq, bus_rd, bus_wr, scan_out0, bus_addr, bus_wdata}, 0);
        reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_breq", dma_breq, 0);

        // Reset in the middle of a stalled read.
        ack_en = 1'b0;
        start = 1'b1; src_addr = 16'h0500; dst_addr = 16'h0600; xfer_cnt = 8'd5;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("midxfer_rd", bus_rd, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", {busy, done_irq, dma_breq, bus_rd, bus_wr, scan_out0, bus_addr, bus_wdata}, 0);
        repeat (2) step();
        reset = 1'b1; ack_en = 1'b1;
        repeat (3) step();
        chk("post_reset_busy", busy, 0);
        chk("post_reset_breq", dma_breq, 0);

        // Basic transfer.
        push_xfer(16'h0100, 16'h0200, 3);
        ten_q.push_back(3);
        run_xfer(16'h0100, 16'h0200, 8'd3, "basic");
        chk("scan_out_functional", scan_out0, 0);

        // Zero-length transfer.
        done_q.push_back(1'b1);
        start = 1'b1; xfer_cnt = 8'd0; src_addr = 16'h1234; dst_addr = 16'h4321;
        step();
        start = 1'b0;
        chk("zero_done_c1", done_irq, 1);
        chk("zero_breq_c1", dma_breq, 0);
        chk("zero_busy_c1", busy, 0);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (dma_breq || done_irq || busy) got = 1'b1;
        end
        chk("zero_quiet", got, 0);

        // Address wrap.
        push_xfer(16'hFFFF, 16'hFFFE, 3);
        ten_q.push_back(3);
        run_xfer(16'hFFFF, 16'hFFFE, 8'd3, "wrap");

        // Grant lost during a read with no ack: the word is retried at the same address.
        push_xfer(16'h0300, 16'h0400, 2);
        ten_q.push_back(2);
        ack_en = 1'b0;
        step();
        start = 1'b1; src_addr = 16'h0300; dst_addr = 16'h0400; xfer_cnt = 8'd2;
        step();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus_rd) got = 1'b1;
            else step();
        end
        chk("gl_rd_seen", got, 1);
        chk("gl_rd_addr", bus_addr, 16'h0300);
        grant_allow = 1'b0;
        step();
        chk("gl_rd_hold", bus_rd, 1);
        step();
        chk("gl_rd_dropped", bus_rd, 0);
        chk("gl_breq_kept", dma_breq, 1);
        chk("gl_busy_kept", busy, 1);
        step();
        chk("gl_no_rd_while_ungranted", bus_rd, 0);
        ack_en = 1'b1; grant_allow = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            if (done_irq) got = 1'b1;
        end
        chk("gl_done_seen", got, 1);
        step();
        chk("gl_busy_after", busy, 0);

        // Burst limit: 10 words.
        push_xfer(16'h1000, 16'h2000, 10);
`ifdef DMA_BURST_LIMIT_EN
        ten_q.push_back(4);
        ten_q.push_back(4);
        ten_q.push_back(2);
`else
        ten_q.push_back(10);
`endif
        run_xfer(16'h1000, 16'h2000, 8'd10, "burst");

        repeat (4) step();
        chk("acc_queue_empty", exp_q.size(), 0);
        chk("tenure_queue_empty", ten_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
